// File: rtl/mmio_pkg.sv
// Shared constants and types for the CPU/DMA memory arbiter.
// MMIO register map, requester ids, arbiter state encoding and read-tag layout.
package mmio_pkg;

  localparam int unsigned MMIO_BTNU   = 1000;
  localparam int unsigned MMIO_LED    = 1001;
  localparam int unsigned MMIO_BRIGHT = 1002;
  localparam int unsigned MMIO_LO     = MMIO_BTNU;
  localparam int unsigned MMIO_HI     = MMIO_BRIGHT;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_C = 2'd1,
    LOCK_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/mmio_rd_tag_pipe.sv
// Read owner tag delay line, DEPTH stages deep, so each read response can be
// steered back to the requester that issued it.
module mmio_rd_tag_pipe
  import mmio_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mmio_mem_arbiter.sv
// Two-requester (CPU, pixel DMA) arbiter in front of the single-port memory/MMIO block.
// CPU priority with DMA starvation guard, burst locks, and DMA write protection of MMIO.
//
// state  | meaning
// IDLE   | arbitrate every cycle, CPU first unless DMA has waited MAX_WAIT cycles
// LOCK_C | CPU owns the memory until it drops c_lock or c_req
// LOCK_D | DMA owns the memory until it drops d_lock/d_req or the CPU has waited MAX_WAIT
module mmio_mem_arbiter
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned MMIO_LO  = mmio_pkg::MMIO_LO,
  parameter int unsigned MMIO_HI  = mmio_pkg::MMIO_HI
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_lock,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  arb_state_e        r_state, w_state_nxt;
  logic [7:0]        r_c_wait, r_d_wait;
  logic              w_c_win, w_d_win;
  logic              w_c_gnt, w_d_gnt;
  logic              w_c_starved, w_d_starved;
  logic              w_d_mmio;
  logic              w_c_ret, w_d_ret;
  rd_tag_t           w_issue_tag, w_ret_tag;
  logic [DATA_W-1:0] r_c_rdata, r_d_rdata;

  assign w_c_starved = (r_c_wait == 8'(MAX_WAIT));
  assign w_d_starved = (r_d_wait == 8'(MAX_WAIT));
  assign w_d_mmio    = in_window(32'(d_addr), 32'(MMIO_LO), 32'(MMIO_HI));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_c_win     = 1'b0;
    w_d_win     = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req && (!c_req || w_d_starved)) begin
          w_d_win = 1'b1;
          if (d_lock) w_state_nxt = LOCK_D;
        end else if (c_req) begin
          w_c_win = 1'b1;
          if (c_lock) w_state_nxt = LOCK_C;
        end
      end
      LOCK_C: begin
        if (c_req) begin
          w_c_win = 1'b1;
          if (!c_lock) w_state_nxt = IDLE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOCK_D: begin
        // A starved CPU breaks the DMA lock; the CPU then wins the next IDLE cycle.
        if (c_req && w_c_starved) begin
          w_state_nxt = IDLE;
        end else if (d_req) begin
          w_d_win = 1'b1;
          if (!d_lock) w_state_nxt = IDLE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grants are combinational, so hold them low while reset is asserted.
  assign w_c_gnt = w_c_win & rst_n;
  assign w_d_gnt = w_d_win & rst_n;
  assign c_gnt   = w_c_gnt;
  assign d_gnt   = w_d_gnt;
  assign d_err   = w_d_gnt & d_we & w_d_mmio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_wait <= '0;
      r_d_wait <= '0;
    end else begin
      if (!c_req || w_c_gnt)  r_c_wait <= '0;
      else if (!w_c_starved)  r_c_wait <= r_c_wait + 8'd1;
      if (!d_req || w_d_gnt)  r_d_wait <= '0;
      else if (!w_d_starved)  r_d_wait <= r_d_wait + 8'd1;
    end
  end

  always_comb begin
    mem_wEn    = 1'b0;
    mem_addr   = '0;
    mem_dataIn = '0;
    if (w_c_gnt) begin
      mem_wEn    = c_we;
      mem_addr   = c_addr;
      mem_dataIn = c_wdata;
    end else if (w_d_gnt) begin
      mem_wEn    = d_we & ~w_d_mmio;
      mem_addr   = d_addr;
      mem_dataIn = d_wdata;
    end
  end

  assign w_issue_tag.valid = (w_c_gnt & ~c_we) | (w_d_gnt & ~d_we);
  assign w_issue_tag.id    = w_d_gnt ? REQ_DMA : REQ_CPU;

  mmio_rd_tag_pipe #(
    .DEPTH(READ_LAT)
  ) u_rd_tag_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .i_tag(w_issue_tag),
    .o_tag(w_ret_tag)
  );

  assign w_c_ret = w_ret_tag.valid && (w_ret_tag.id == REQ_CPU);
  assign w_d_ret = w_ret_tag.valid && (w_ret_tag.id == REQ_DMA);

  // Memory dataOut is only valid during the return cycle; keep a copy for the idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_c_ret) r_c_rdata <= mem_dataOut;
      if (w_d_ret) r_d_rdata <= mem_dataOut;
    end
  end

  assign c_rvalid = w_c_ret;
  assign d_rvalid = w_d_ret;
  assign c_rdata  = w_c_ret ? mem_dataOut : r_c_rdata;
  assign d_rdata  = w_d_ret ? mem_dataOut : r_d_rdata;

endmodule

// File: tb/tb_mmio_mem_arbiter.sv
// Directed bench for mmio_mem_arbiter: one instance at READ_LAT=1 and one at READ_LAT=2
// share the same requester stimulus, each with its own behavioural RAM.
module tb_mmio_mem_arbiter;

  logic        clk, rst_n;
  logic        c_req, c_we, c_lock, d_req, d_we, d_lock;
  logic [11:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;

  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, d_err, mem_wEn;
  logic [31:0] c_rdata, d_rdata, mem_dataIn, mem_dataOut;
  logic [11:0] mem_addr;

  logic        c_gnt2, c_rvalid2, d_gnt2, d_rvalid2, d_err2, mem_wEn2;
  logic [31:0] c_rdata2, d_rdata2, mem_dataIn2, mem_dataOut2;
  logic [11:0] mem_addr2;

  logic [31:0] ram1 [4096];
  logic [31:0] ram2 [4096];
  logic [31:0] rd2a;
  logic        pk_en;
  logic [11:0] pk_addr;
  logic [31:0] pk_data;

  int checks, errors;

  mmio_mem_arbiter #(.READ_LAT(1), .MAX_WAIT(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  mmio_mem_arbiter #(.READ_LAT(2), .MAX_WAIT(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt2), .c_rvalid(c_rvalid2), .c_rdata(c_rdata2),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2), .d_err(d_err2),
    .mem_wEn(mem_wEn2), .mem_addr(mem_addr2), .mem_dataIn(mem_dataIn2), .mem_dataOut(mem_dataOut2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pk_en) begin
      ram1[pk_addr] <= pk_data;
      ram2[pk_addr] <= pk_data;
    end else begin
      if (mem_wEn)  ram1[mem_addr]  <= mem_dataIn;
      if (mem_wEn2) ram2[mem_addr2] <= mem_dataIn2;
    end
    mem_dataOut  <= ram1[mem_addr];
    rd2a         <= ram2[mem_addr2];
    mem_dataOut2 <= rd2a;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic poke(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    pk_en = 1'b1; pk_addr = a; pk_data = v;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic clear_reqs();
    c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_reqs();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pk_en = 1'b0;
    clear_reqs();
    poke(12'd5, 32'hDEADBEEF);
    poke(12'd1001, 32'h0);
    for (int i = 0; i < 4; i++) poke(12'(100 + i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 6; i++) poke(12'(200 + i), 32'hB000_0000 + 32'(i));
    #1;
    checks++;
    if ({c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata, d_err, mem_wEn, mem_addr, mem_dataIn} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b/%b rv=%b/%b we=%b addr=%0d", c_gnt, d_gnt, c_rvalid, d_rvalid, mem_wEn, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    c_req = 1; c_addr = 12'd5;
    #1;
    checks++;
    if ({c_gnt, d_gnt, mem_wEn, mem_addr} !== {1'b1, 1'b0, 1'b0, 12'd5}) begin
      errors++;
      $display("FAIL cpu_read_gnt got c_gnt=%b d_gnt=%b we=%b addr=%0d exp 1 0 0 5", c_gnt, d_gnt, mem_wEn, mem_addr);
    end
    @(negedge clk);
    c_req = 0;
    #1;
    checks++;
    if ({c_rvalid, c_rdata, d_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL cpu_read_data got rv=%b data=%h d_rv=%b exp 1 deadbeef 0", c_rvalid, c_rdata, d_rvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({c_rvalid, c_rdata, c_rvalid2, c_rdata2} !== {1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL cpu_read_hold got rv=%b data=%h rv2=%b data2=%h", c_rvalid, c_rdata, c_rvalid2, c_rdata2);
    end
    idle(2);
  endtask

  task automatic test_starvation();
    logic exp_d;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      c_req = 1; c_addr = 12'd5; d_req = 1; d_addr = 12'd5;
      #1;
      exp_d = (i % 9 == 0);
      checks++;
      if ({c_gnt, d_gnt} !== {~exp_d, exp_d}) begin
        errors++;
        $display("FAIL starve_cycle%0d got c=%b d=%b exp c=%b d=%b", i, c_gnt, d_gnt, ~exp_d, exp_d);
      end
    end
    idle(3);
  endtask

  task automatic test_mmio_protect();
    logic [11:0] ta [4];
    logic        te [4];
    ta = '{12'd999, 12'd1000, 12'd1002, 12'd1003};
    te = '{1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 12'd1001; d_wdata = 32'h1F;
    #1;
    checks++;
    if ({d_gnt, d_err, mem_wEn, c_gnt} !== 4'b1100) begin
      errors++;
      $display("FAIL dma_led_write got gnt=%b err=%b we=%b exp 1 1 0", d_gnt, d_err, mem_wEn);
    end
    @(negedge clk);
    clear_reqs();
    #1;
    checks++;
    if ({d_err, ram1[1001]} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL dma_led_blocked got err=%b led=%h exp 0 0", d_err, ram1[1001]);
    end
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 12'd1001; c_wdata = 32'h1F;
    #1;
    checks++;
    if ({c_gnt, mem_wEn, mem_dataIn, d_err} !== {1'b1, 1'b1, 32'h1F, 1'b0}) begin
      errors++;
      $display("FAIL cpu_led_write got gnt=%b we=%b din=%h err=%b", c_gnt, mem_wEn, mem_dataIn, d_err);
    end
    @(negedge clk);
    clear_reqs();
    #1;
    checks++;
    if ({ram1[1001], c_rvalid} !== {32'h1F, 1'b0}) begin
      errors++;
      $display("FAIL cpu_led_value got led=%h rv=%b exp 1f 0", ram1[1001], c_rvalid);
    end
    @(negedge clk);
    d_req = 1; d_addr = 12'd1001;
    #1;
    checks++;
    if ({d_gnt, d_err} !== 2'b10) begin
      errors++;
      $display("FAIL dma_mmio_read_gnt got gnt=%b err=%b exp 1 0", d_gnt, d_err);
    end
    @(negedge clk);
    clear_reqs();
    #1;
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'h1F}) begin
      errors++;
      $display("FAIL dma_mmio_read_data got rv=%b data=%h exp 1 1f", d_rvalid, d_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_req = 1; d_we = 1; d_addr = ta[i]; d_wdata = 32'h55;
      #1;
      checks++;
      if ({d_gnt, d_err, mem_wEn} !== {1'b1, te[i], ~te[i]}) begin
        errors++;
        $display("FAIL dma_window_edge%0d got gnt=%b err=%b we=%b exp 1 %b %b", ta[i], d_gnt, d_err, mem_wEn, te[i], ~te[i]);
      end
    end
    idle(3);
  endtask

  task automatic test_lock_burst();
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      d_req  = (k < 4);
      d_lock = (k < 3);
      d_addr = 12'(100 + k);
      c_req  = (k >= 1) && (k <= 4);
      c_addr = 12'd5;
      #1;
      if (k <= 4) begin
        checks++;
        if ({d_gnt, c_gnt} !== {(k < 4) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0}) begin
          errors++;
          $display("FAIL lock_burst_gnt%0d got d=%b c=%b", k, d_gnt, c_gnt);
        end
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'hA000_0000 + 32'(k - 1)}) begin
          errors++;
          $display("FAIL lock_burst_data%0d got rv=%b data=%h exp %h", k, d_rvalid, d_rdata, 32'hA000_0000 + 32'(k - 1));
        end
      end
      if (k == 5) begin
        checks++;
        if ({c_rvalid, c_rdata, d_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
          errors++;
          $display("FAIL lock_burst_cpu got rv=%b data=%h d_rv=%b", c_rvalid, c_rdata, d_rvalid);
        end
      end
    end
    idle(3);
  endtask

  task automatic test_lock_guard();
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      d_req = 1; d_lock = 1; d_addr = 12'd100;
      c_req = (j >= 1); c_addr = 12'd5;
      #1;
      checks++;
      if ({d_gnt, c_gnt} !== {(j <= 8) ? 1'b1 : 1'b0, (j == 10) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("FAIL lock_guard%0d got d=%b c=%b", j, d_gnt, c_gnt);
      end
    end
    idle(4);
  endtask

  task automatic test_alt_lat2();
    int src;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      c_req  = (k < 6) && (k % 2 == 0);
      d_req  = (k < 6) && (k % 2 == 1);
      c_addr = 12'(200 + k);
      d_addr = 12'(200 + k);
      #1;
      if (k < 6) begin
        checks++;
        if ({c_gnt2, d_gnt2} !== {c_req, d_req}) begin
          errors++;
          $display("FAIL alt_gnt%0d got c=%b d=%b", k, c_gnt2, d_gnt2);
        end
      end
      checks++;
      if (k < 2) begin
        if ({c_rvalid2, d_rvalid2} !== 2'b00) begin
          errors++;
          $display("FAIL alt_early%0d got c_rv=%b d_rv=%b exp 0 0", k, c_rvalid2, d_rvalid2);
        end
      end else begin
        src = k - 2;
        if (src % 2 == 0) begin
          if ({c_rvalid2, c_rdata2, d_rvalid2} !== {1'b1, 32'hB000_0000 + 32'(src), 1'b0}) begin
            errors++;
            $display("FAIL alt_cpu%0d got rv=%b data=%h d_rv=%b", k, c_rvalid2, c_rdata2, d_rvalid2);
          end
        end else begin
          if ({d_rvalid2, d_rdata2, c_rvalid2} !== {1'b1, 32'hB000_0000 + 32'(src), 1'b0}) begin
            errors++;
            $display("FAIL alt_dma%0d got rv=%b data=%h c_rv=%b", k, d_rvalid2, d_rdata2, c_rvalid2);
          end
        end
      end
    end
    idle(3);
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    c_req = 1; c_addr = 12'd5;
    #1;
    checks++;
    if (c_gnt !== 1'b1) begin
      errors++;
      $display("FAIL inflight_gnt got %b exp 1", c_gnt);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata, d_err, mem_wEn, mem_addr, mem_dataIn,
         c_gnt2, c_rvalid2, c_rdata2, d_rvalid2, d_rdata2, mem_addr2} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs got gnt=%b rv=%b/%b data=%h addr=%0d", c_gnt, c_rvalid, c_rvalid2, c_rdata, mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      c_req = 0;
      if (i == 2) rst_n = 1'b1;
      #1;
      checks++;
      if ({c_rvalid, d_rvalid, c_rvalid2, d_rvalid2} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_no_rvalid%0d got %b%b%b%b exp 0000", i, c_rvalid, d_rvalid, c_rvalid2, d_rvalid2);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({c_rvalid, c_rvalid2} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_rv got %b%b exp 00", c_rvalid, c_rvalid2);
    end
    @(negedge clk);
    c_req = 1; c_addr = 12'd5;
    #1;
    checks++;
    if ({c_gnt, mem_addr} !== {1'b1, 12'd5}) begin
      errors++;
      $display("FAIL post_reset_gnt got gnt=%b addr=%0d exp 1 5", c_gnt, mem_addr);
    end
    @(negedge clk);
    c_req = 0;
    #1;
    checks++;
    if ({c_rvalid, c_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL post_reset_data got rv=%b data=%h exp 1 deadbeef", c_rvalid, c_rdata);
    end
    idle(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cpu_read();
    test_starvation();
    test_mmio_protect();
    test_lock_burst();
    test_lock_guard();
    test_alt_lat2();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
